// File: rtl/vec_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_decode_pkg                                               |
// | Description : Opcode / register-class encodings and decoded-bundle types   |
// |               shared by the vector decode stage and its scoreboard.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package vec_decode_pkg;

  localparam logic [2:0] OP_MOV_SI  = 3'b000;
  localparam logic [2:0] OP_MOV_SV  = 3'b001;
  localparam logic [2:0] OP_ADD_SI  = 3'b010;
  localparam logic [2:0] OP_SUB_SI  = 3'b011;
  localparam logic [2:0] OP_MUL_VS  = 3'b100;
  localparam logic [2:0] OP_ADD_VV  = 3'b101;
  localparam logic [2:0] OP_DIV_VS  = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  localparam logic [2:0] RT_SV     = 3'b000;
  localparam logic [2:0] RT_VS     = 3'b001;
  localparam logic [2:0] RT_SIMM   = 3'b010;
  localparam logic [2:0] RT_VV     = 3'b011;
  localparam logic [2:0] RT_SARITH = 3'b100;

  localparam int VD_REG_AW = 3;
  localparam int VD_IMM_W  = 8;

  typedef struct packed {
    logic [4:0] ex_ctrl;
    logic [3:0] mem_ctrl;
    logic [1:0] wb_ctrl;
    logic [2:0] reg_type;
    logic       des_type;
    logic       illegal;
  } vd_ctrl_t;

  typedef struct packed {
    vd_ctrl_t               ctrl;
    logic [VD_REG_AW-1:0]   oper1;
    logic [VD_REG_AW-1:0]   oper2;
    logic [VD_REG_AW-1:0]   oper3;
    logic [VD_IMM_W-1:0]    imm;
  } vd_bundle_t;

  function automatic logic op_is_vs(input logic [2:0] op);
    return (op == OP_MUL_VS) || (op == OP_DIV_VS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_decode_stage_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_scoreboard                                               |
// | Description : Pending-write bits for scalar and vector register files,     |
// |               index = {is_vec, reg}. Set wins over a same-cycle clear.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vec_scoreboard
  import vec_decode_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set_en,
  input  logic [REG_AW:0] i_set_idx,
  input  logic            i_clr_en,
  input  logic [REG_AW:0] i_clr_idx,
  input  logic [REG_AW:0] i_dst_idx,
  input  logic [REG_AW:0] i_src_a_idx,
  input  logic [REG_AW:0] i_src_b_idx,
  input  logic [REG_AW:0] i_src_c_idx,
  output logic            o_dst_busy,
  output logic            o_src_a_busy,
  output logic            o_src_b_busy,
  output logic            o_src_c_busy
);

  localparam int c_DEPTH = 2 ** (REG_AW + 1);

  logic [c_DEPTH-1:0] r_pending;

  // Set is written last so it overrides a clear of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      if (i_clr_en) r_pending[i_clr_idx] <= 1'b0;
      if (i_set_en) r_pending[i_set_idx] <= 1'b1;
    end
  end

  assign o_dst_busy   = r_pending[i_dst_idx];
  assign o_src_a_busy = r_pending[i_src_a_idx];
  assign o_src_b_busy = r_pending[i_src_b_idx];
  assign o_src_c_busy = r_pending[i_src_c_idx];

endmodule
`default_nettype wire

// File: rtl/vec_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vec_decode_stage                                             |
// | Description : Registered instruction-decode stage with valid/ready on both |
// |               sides. Define HAZARD_CHECK_EN to build the RAW/WAW scoreboard|
// |               stall; otherwise writeback inputs are ignored.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vec_decode_stage
  import vec_decode_pkg::*;
#(
  parameter int INSTR_W = 20,
  parameter int REG_AW  = 3,
  parameter int IMM_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         ex_ctrl,
  output logic [3:0]         mem_ctrl,
  output logic [1:0]         wb_ctrl,
  output logic [REG_AW-1:0]  oper1,
  output logic [REG_AW-1:0]  oper2,
  output logic [REG_AW-1:0]  oper3,
  output logic [IMM_W-1:0]   imm,
  output logic [2:0]         reg_type,
  output logic               des_type,
  output logic               illegal,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_reg,
  input  logic               wb_is_vec
);

  localparam int c_TOP = INSTR_W - 1;

  logic              w_funct;
  logic [2:0]        w_op;
  logic [1:0]        w_wb;
  logic [REG_AW-1:0] w_f1, w_f2, w_f3;
  logic [IMM_W-1:0]  w_imm_fld;

  assign w_funct   = in_instr[c_TOP];
  assign w_op      = in_instr[c_TOP-1 -: 3];
  assign w_wb      = in_instr[c_TOP-4 -: 2];
  assign w_f1      = in_instr[c_TOP-6 -: REG_AW];
  assign w_f2      = in_instr[c_TOP-6-REG_AW -: REG_AW];
  assign w_f3      = in_instr[c_TOP-6-2*REG_AW -: REG_AW];
  assign w_imm_fld = in_instr[IMM_W-1:0];

  vd_ctrl_t          w_ctrl;
  logic [REG_AW-1:0] w_oper1, w_oper2, w_oper3;
  logic [IMM_W-1:0]  w_imm;
  logic              w_imm_sel;
  logic              w_write;
  logic              w_src_a_en, w_src_b_en, w_src_c_en;
  logic [REG_AW:0]   w_src_a_idx, w_src_b_idx, w_src_c_idx;
  logic [REG_AW:0]   w_dst_idx;

  // Source slots: a reads via f2, b via f3, c via f1.
  always_comb begin
    w_ctrl      = '0;
    w_oper1     = '0;
    w_oper2     = '0;
    w_oper3     = '0;
    w_imm       = '0;
    w_imm_sel   = 1'b0;
    w_write     = 1'b0;
    w_src_a_en  = 1'b0;
    w_src_b_en  = 1'b0;
    w_src_c_en  = 1'b0;
    w_src_a_idx = '0;
    w_src_b_idx = '0;
    w_src_c_idx = '0;
    if (w_funct) begin
      w_oper1         = w_f1;
      w_oper2         = w_f2;
      w_ctrl.reg_type = RT_VS;
      w_ctrl.des_type = 1'b1;
      w_src_a_en      = 1'b1;
      w_src_a_idx     = {1'b0, w_f2};
      if (w_op[0]) begin
        w_src_c_en  = 1'b1;
        w_src_c_idx = {1'b1, w_f1};
      end else begin
        w_write = w_wb[0];
      end
    end else begin
      case (w_op)
        OP_MOV_SI: begin
          w_oper1         = w_f1;
          w_imm           = w_imm_fld;
          w_ctrl.reg_type = RT_SIMM;
          w_imm_sel       = 1'b1;
          w_write         = w_wb[0];
        end
        OP_MOV_SV: begin
          w_oper1         = w_f1;
          w_oper2         = w_f2;
          w_ctrl.reg_type = RT_SV;
          w_ctrl.des_type = 1'b1;
          w_src_a_en      = 1'b1;
          w_src_a_idx     = {1'b0, w_f2};
          w_write         = w_wb[0];
        end
        OP_ADD_SI, OP_SUB_SI: begin
          w_oper1         = w_f1;
          w_imm           = w_imm_fld;
          w_ctrl.reg_type = RT_SARITH;
          w_imm_sel       = 1'b1;
          w_src_c_en      = 1'b1;
          w_src_c_idx     = {1'b0, w_f1};
          w_write         = w_wb[0];
        end
        OP_MUL_VS, OP_DIV_VS, OP_ADD_VV: begin
          w_oper1         = w_f1;
          w_oper2         = w_f2;
          w_oper3         = w_f3;
          w_ctrl.reg_type = op_is_vs(w_op) ? RT_VS : RT_VV;
          w_ctrl.des_type = 1'b1;
          w_src_a_en      = 1'b1;
          w_src_a_idx     = {1'b1, w_f2};
          w_src_b_en      = 1'b1;
          w_src_b_idx     = {~op_is_vs(w_op), w_f3};
          w_write         = w_wb[0];
        end
        default: begin
          w_ctrl.illegal = 1'b1;
        end
      endcase
    end
    w_ctrl.ex_ctrl  = {w_funct, w_op, w_imm_sel};
    w_ctrl.mem_ctrl = {w_funct, w_op};
    w_ctrl.wb_ctrl  = w_ctrl.illegal ? 2'b00 : {w_wb[1], w_write};
  end

  assign w_dst_idx = {w_ctrl.des_type, w_f1};

  logic r_out_valid;
  logic w_hazard;
  logic w_accept;

  assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && in_ready;

`ifdef HAZARD_CHECK_EN
  logic w_dst_busy, w_a_busy, w_b_busy, w_c_busy;

  vec_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_set_en     (w_accept && w_write),
    .i_set_idx    (w_dst_idx),
    .i_clr_en     (wb_valid),
    .i_clr_idx    ({wb_is_vec, wb_reg}),
    .i_dst_idx    (w_dst_idx),
    .i_src_a_idx  (w_src_a_idx),
    .i_src_b_idx  (w_src_b_idx),
    .i_src_c_idx  (w_src_c_idx),
    .o_dst_busy   (w_dst_busy),
    .o_src_a_busy (w_a_busy),
    .o_src_b_busy (w_b_busy),
    .o_src_c_busy (w_c_busy)
  );

  assign w_hazard = (w_write    && w_dst_busy) ||
                    (w_src_a_en && w_a_busy)   ||
                    (w_src_b_en && w_b_busy)   ||
                    (w_src_c_en && w_c_busy);
`else
  logic w_unused_hz;
  assign w_hazard    = 1'b0;
  assign w_unused_hz = ^{wb_valid, wb_reg, wb_is_vec, w_src_a_en, w_src_b_en, w_src_c_en,
                         w_src_a_idx, w_src_b_idx, w_src_c_idx, w_dst_idx};
`endif

  vd_ctrl_t          r_ctrl;
  logic [REG_AW-1:0] r_oper1, r_oper2, r_oper3;
  logic [IMM_W-1:0]  r_imm;

  // Bundle registers load only on accept, so they are held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_oper1     <= '0;
      r_oper2     <= '0;
      r_oper3     <= '0;
      r_imm       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_ctrl      <= w_ctrl;
      r_oper1     <= w_oper1;
      r_oper2     <= w_oper2;
      r_oper3     <= w_oper3;
      r_imm       <= w_imm;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign ex_ctrl   = r_ctrl.ex_ctrl;
  assign mem_ctrl  = r_ctrl.mem_ctrl;
  assign wb_ctrl   = r_ctrl.wb_ctrl;
  assign reg_type  = r_ctrl.reg_type;
  assign des_type  = r_ctrl.des_type;
  assign illegal   = r_ctrl.illegal;
  assign oper1     = r_oper1;
  assign oper2     = r_oper2;
  assign oper3     = r_oper3;
  assign imm       = r_imm;

endmodule
`default_nettype wire

// File: tb/tb_vec_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vec_decode_stage                                          |
// | Description : Directed plus random bench for vec_decode_stage against a    |
// |               table-driven reference model (honours HAZARD_CHECK_EN).      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_vec_decode_stage;

  localparam int INSTR_W = 20;
  localparam int REG_AW  = 3;
  localparam int IMM_W   = 8;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, wb_valid, wb_is_vec;
  logic [19:0] in_instr;
  logic [2:0]  wb_reg;
  logic        in_ready, out_valid, des_type, illegal;
  logic [4:0]  ex_ctrl;
  logic [3:0]  mem_ctrl;
  logic [1:0]  wb_ctrl;
  logic [2:0]  oper1, oper2, oper3, reg_type;
  logic [7:0]  imm;

  always #5 clk = ~clk;

  vec_decode_stage #(.INSTR_W(INSTR_W), .REG_AW(REG_AW), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .oper1(oper1), .oper2(oper2), .oper3(oper3), .imm(imm),
    .reg_type(reg_type), .des_type(des_type), .illegal(illegal),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_is_vec(wb_is_vec)
  );

  typedef struct packed {
    logic [4:0] ex;
    logic [3:0] mem;
    logic [1:0] wb;
    logic [2:0] o1, o2, o3;
    logic [7:0] im;
    logic [2:0] rt;
    logic       des;
    logic       ill;
  } bund_t;

  bund_t dut_b;
  assign dut_b = {ex_ctrl, mem_ctrl, wb_ctrl, oper1, oper2, oper3, imm, reg_type, des_type, illegal};

  // Reference state: pending writes indexed 0..7 scalar, 8..15 vector.
  bit    pend [16];
  bit    m_ov;
  bund_t m_b;
  bund_t d_b;
  int    d_src [3];
  int    d_nsrc;
  int    d_dst;
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_src(input int idx);
    d_src[d_nsrc] = idx;
    d_nsrc++;
  endtask

  task automatic model_decode(input logic [19:0] ins);
    logic [2:0] op, r1, r2, r3;
    logic       w0;
    op = ins[18:16]; w0 = ins[14];
    r1 = ins[13:11]; r2 = ins[10:8]; r3 = ins[7:5];
    d_b = '0; d_nsrc = 0; d_dst = -1;
    d_b.mem = ins[19:16];
    d_b.ex  = {ins[19:16], 1'b0};
    if (ins[19]) begin
      d_b.o1 = r1; d_b.o2 = r2; d_b.rt = 3'd1; d_b.des = 1'b1;
      add_src(int'(r2));
      if (op[0]) add_src(8 + int'(r1));
      else if (w0) d_dst = 8 + int'(r1);
    end else begin
      case (op)
        3'd0: begin
          d_b.o1 = r1; d_b.im = ins[7:0]; d_b.rt = 3'd2; d_b.ex[0] = 1'b1;
          if (w0) d_dst = int'(r1);
        end
        3'd1: begin
          d_b.o1 = r1; d_b.o2 = r2; d_b.rt = 3'd0; d_b.des = 1'b1;
          add_src(int'(r2));
          if (w0) d_dst = 8 + int'(r1);
        end
        3'd2, 3'd3: begin
          d_b.o1 = r1; d_b.im = ins[7:0]; d_b.rt = 3'd4; d_b.ex[0] = 1'b1;
          add_src(int'(r1));
          if (w0) d_dst = int'(r1);
        end
        3'd4, 3'd6: begin
          d_b.o1 = r1; d_b.o2 = r2; d_b.o3 = r3; d_b.rt = 3'd1; d_b.des = 1'b1;
          add_src(8 + int'(r2)); add_src(int'(r3));
          if (w0) d_dst = 8 + int'(r1);
        end
        3'd5: begin
          d_b.o1 = r1; d_b.o2 = r2; d_b.o3 = r3; d_b.rt = 3'd3; d_b.des = 1'b1;
          add_src(8 + int'(r2)); add_src(8 + int'(r3));
          if (w0) d_dst = 8 + int'(r1);
        end
        default: d_b.ill = 1'b1;
      endcase
    end
    if (!d_b.ill) d_b.wb = {ins[15], d_dst >= 0};
  endtask

  function automatic logic model_ready();
    logic rdy;
    rdy = !m_ov || out_ready;
`ifdef HAZARD_CHECK_EN
    for (int i = 0; i < d_nsrc; i++) if (pend[d_src[i]]) rdy = 1'b0;
    if (d_dst >= 0 && pend[d_dst]) rdy = 1'b0;
`endif
    return rdy;
  endfunction

  // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    logic rdy, acc;
    #2;
    model_decode(in_instr);
    rdy = model_ready();
    if (!rst) chk("in_ready", 64'(in_ready), 64'(rdy));
    acc = in_valid && rdy && !rst;
    @(posedge clk);
    if (rst) begin
      foreach (pend[i]) pend[i] = 1'b0;
      m_ov = 1'b0;
      m_b  = '0;
    end else begin
`ifdef HAZARD_CHECK_EN
      if (wb_valid) pend[int'({wb_is_vec, wb_reg})] = 1'b0;
      if (acc && d_dst >= 0) pend[d_dst] = 1'b1;
`endif
      if (acc) begin
        m_ov = 1'b1;
        m_b  = d_b;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("bundle", 64'(dut_b), 64'(m_b));
  endtask

  task automatic wb_pulse(input logic vec, input logic [2:0] r);
    wb_valid = 1'b1; wb_is_vec = vec; wb_reg = r;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [3:0]  k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    wb_valid = 1'b0; wb_reg = '0; wb_is_vec = 1'b0;
    step(); step();
    rst = 1'b0;

    // mov S3 <- 0x5A
    in_instr = 20'h0585A; in_valid = 1'b1;
    step();
    chk("t1_oper1", 64'(oper1), 64'd3);
    chk("t1_imm", 64'(imm), 64'h5A);
    chk("t1_ex", 64'(ex_ctrl), 64'b00001);
    chk("t1_wb", 64'(wb_ctrl), 64'b01);
    chk("t1_rt", 64'(reg_type), 64'b010);

    // v1 = v2*s3 waits on S3 until writeback clears it
    in_instr = 20'h44A60;
    step(); step();
    wb_pulse(1'b0, 3'd3);
    step();
    chk("t2_opers", 64'({oper1, oper2, oper3}), 64'b001_010_011);
    chk("t2_rt", 64'(reg_type), 64'b001);
    in_valid = 1'b0;
    wb_pulse(1'b1, 3'd1);

    // v1 = v2+v3, then downstream stall for 3 cycles
    in_instr = 20'h54A60; in_valid = 1'b1;
    step();
    in_instr = 20'h0285A; out_ready = 1'b0;
    repeat (3) step();
    chk("t3_hold_ready", 64'(in_ready), 64'd0);
    chk("t3_rt", 64'(reg_type), 64'b011);
    out_ready = 1'b1; in_valid = 1'b0;
    step(); step();
    chk("t3_drained", 64'(out_valid), 64'd0);
    wb_pulse(1'b1, 3'd1);

    // illegal opcode
    in_instr = 20'h70000; in_valid = 1'b1;
    step();
    chk("t4_illegal", 64'(illegal), 64'd1);
    chk("t4_fields", 64'({oper1, oper2, oper3, imm, reg_type}), 64'd0);

    // clear and set of V1 on the same edge: the set survives
    in_instr = 20'h14800; wb_valid = 1'b1; wb_is_vec = 1'b1; wb_reg = 3'd1;
    step();
    wb_valid = 1'b0; in_instr = 20'h54A60;
    step(); step();

    // reset while holding a bundle
    out_ready = 1'b0; in_instr = 20'h0585A;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_instr = 20'h54A60; out_ready = 1'b1;
    step();

    // random traffic
    repeat (600) begin
      rnd       = $urandom;
      in_instr  = rnd[19:0];
      if ($urandom_range(0, 3) != 0) in_instr[14] = 1'b1;
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 2) == 0);
      k         = 4'($urandom_range(0, 15));
      wb_is_vec = k[3];
      wb_reg    = k[2:0];
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/vec_decode_stage.md
Name: vec_decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage for the vector processor. It sits between fetch and register-read.
- Decodes one instruction word per accepted transfer into EX/MEM/WB control, operand indices, immediate, register-class and destination-type fields.
- Uses valid/ready handshakes on both sides.
- Keeps a scalar/vector pending-write scoreboard and stalls issue on read-after-write and write-after-write hazards until writeback clears them.

Parameters:
INSTR_W, 20, instruction width; must satisfy INSTR_W >= 6 + 3*REG_AW.
REG_AW, 3, register index width; each of the scalar and vector files has 2**REG_AW registers.
IMM_W, 8, immediate width; must satisfy IMM_W <= INSTR_W - 6 - REG_AW.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts instruction this cycle
in_instr  in  INSTR_W  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
ex_ctrl  out  5  {funct, opcode[2:0], imm_sel}
mem_ctrl  out  4  {funct, opcode[2:0]}
wb_ctrl  out  2  {sel_mux_wb, reg_write}
oper1, oper2, oper3  out  REG_AW each  register indices
imm  out  IMM_W  immediate
reg_type  out  3  operand class: 000 s->v, 001 v-s, 010 s-imm mov, 011 v-v, 100 s-imm arith
des_type  out  1  1 = vector destination, 0 = scalar destination
illegal  out  1  undefined opcode
wb_valid  in  1  writeback retires a register write
wb_reg  in  REG_AW  retired register index
wb_is_vec  in  1  retired register is vector (1) or scalar (0)

Behaviour:
- Field layout, with T = INSTR_W-1:
  - funct = instr[T]; opcode = instr[T-1:T-3]; wb = instr[T-4:T-5].
  - f1, f2, f3 = the next three REG_AW-bit fields, MSB first.
  - imm = instr[IMM_W-1:0].
- Decode table (funct, opcode):
  - 1,xx0: load. oper1 = f1, oper2 = f2, reg_type = 001, des = 1, imm_sel = 0. Reads S[f2].
  - 1,xx1: store. Same fields as load. Reads S[f2] and V[f1]; no register write regardless of wb[0].
  - 0,000: mov scalar immediate. oper1 = f1, imm, reg_type = 010, des = 0, imm_sel = 1. No source reads.
  - 0,001: mov scalar to vector. oper1 = f1, oper2 = f2, reg_type = 000, des = 1, imm_sel = 0. Reads S[f2].
  - 0,010 / 0,011: scalar add / sub immediate. oper1 = f1, imm, reg_type = 100, des = 0, imm_sel = 1. Reads S[f1].
  - 0,100 / 0,110: vector-scalar mul / div. oper1/2/3 = f1/f2/f3, reg_type = 001, des = 1. Reads V[f2] and S[f3].
  - 0,101: vector-vector add. oper1/2/3 = f1/f2/f3, reg_type = 011, des = 1. Reads V[f2] and V[f3].
  - 0,111: illegal = 1. All other outputs are 0 except ex_ctrl/mem_ctrl raw bits. No scoreboard effect.
- Field zeroing: every field not listed for an opcode is driven 0. No field holds a stale value.
- Destination write: an instruction writes only when wb[0] = 1 and it is not a store and not illegal. The destination is V[f1] when des = 1, otherwise S[f1].
- Hazard: raised when any source, or the destination, of in_instr has its scoreboard bit set.
- in_ready = (!out_valid || out_ready) && !hazard. in_ready does not depend on in_valid.
- Accept: an instruction is accepted when in_valid && in_ready.
  - Output registers load on the next clock edge, giving 1-cycle latency.
  - out_valid is set.
  - The destination scoreboard bit is set.
- Hold: while out_valid && !out_ready, all outputs are held stable.
- Drain: out_ready with no accept clears out_valid on the next edge.
- Back-to-back: full throughput, one instruction per cycle, when there are no hazards.
- Scoreboard clear: wb_valid clears bit {wb_is_vec, wb_reg} on the next edge. The scoreboard is registered with no bypass, so a stalled instruction issues one cycle after the clear.
- Simultaneous set and clear of the same bit: the set wins.
- Reset:
  - out_valid = 0, all bundle outputs = 0, illegal = 0, scoreboard all 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-stall drops the held bundle and all pending bits.

Optional Feature:
HAZARD_CHECK_EN
- Defined: scoreboard and hazard stall are built as described above.
- Undefined:
  - No scoreboard is built; hazard = 0.
  - wb_valid, wb_reg and wb_is_vec are ignored.
  - in_ready = !out_valid || out_ready.

Decomposition:
- Package vec_decode_pkg holds:
  - opcode localparams (OP_MOV_SI … OP_ILLEGAL);
  - reg_type localparams (RT_SV, RT_VS, RT_SIMM, RT_VV, RT_SARITH);
  - a decoded-bundle struct typedef, parametrised through REG_AW/IMM_W localparams.
- Sub-module vec_scoreboard holds:
  - 2*2**REG_AW pending bits;
  - set and clear ports;
  - four combinational query ports (dst, src_a, src_b, src_c).

Test Plan:
- Reset then in_instr = 0x0585A, valid, out_ready = 1 -> next cycle out_valid = 1, oper1 = 3, imm = 0x5A, reg_type = 010, des = 0, ex_ctrl = 00001, wb_ctrl = 01; scalar bit S3 set.
- 0x0585A, then 0x44A60 (v1 = v2*s3) -> in_ready = 0 while S3 is pending; wb_valid with wb_reg = 3, wb_is_vec = 0 -> in_ready = 1 the following cycle; bundle shows oper1/2/3 = 1/2/3, reg_type = 001.
- 0x54A60 (v1 = v2+v3) with out_ready held 0 for 3 cycles -> bundle stable, in_ready = 0; release -> one transfer, no duplicate.
- in_instr = 0x70000 (opcode 111) -> illegal = 1, oper/imm/reg_type = 0, scoreboard unchanged.
- wb_valid for V1 on the same edge as accepting another V1 writer -> V1 stays pending.
- Assert rst while stalled with out_valid = 1 -> out_valid = 0, scoreboard clear, in_ready = 1 the next cycle.
